datacmp_seq: RTL and testbench

- Multi-cycle, parametrised magnitude comparator with cascade input; successor to the team's 4-bit cascadable comparator.
- Compares two DATA_W-bit operands CHUNK_W bits per cycle, MSB chunk first, and stops at the first differing chunk.
- Start/ready/valid handshake. Used where wide comparisons must not sit on a single combinational path (timers, sort/select stages).

---
 rtl/datacmp_pkg.sv | 20 ++
 rtl/datacmp_chunk.sv | 26 ++
 rtl/datacmp_seq.sv | 134 +++++++++++++
 tb/tb_datacmp_seq.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datacmp_pkg.sv
// Shared result codes, FSM state encoding and sizing helper for the sequential comparator.
package datacmp_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;

    typedef enum logic {
        StIdle,
        StCmp
    } state_e;

    // Clamped to 1 so a degenerate configuration still yields one compare cycle.
    function automatic int unsigned num_chunks(input int unsigned data_w,
                                               input int unsigned chunk_w);
        int unsigned n;
        n = (chunk_w == 0) ? 1 : data_w / chunk_w;
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/datacmp_chunk.sv
// Combinational CHUNK_W-bit magnitude compare; signed_i selects two's complement for this chunk.
module datacmp_chunk #(
    parameter int unsigned CHUNK_W = 4
) (
    input  logic [CHUNK_W-1:0] a_i,
    input  logic [CHUNK_W-1:0] b_i,
    input  logic               signed_i,
    output logic               gt_o,
    output logic               lt_o
);

    logic [CHUNK_W-1:0] a_adj;
    logic [CHUNK_W-1:0] b_adj;

    // Flipping the sign bit maps two's complement order onto unsigned order.
    always_comb begin
        a_adj = a_i;
        b_adj = b_i;
        a_adj[CHUNK_W-1] = a_i[CHUNK_W-1] ^ signed_i;
        b_adj[CHUNK_W-1] = b_i[CHUNK_W-1] ^ signed_i;
    end

    assign gt_o = (a_adj > b_adj);
    assign lt_o = (a_adj < b_adj);

endmodule

// File: rtl/datacmp_seq.sv
// Multi-cycle chunked magnitude comparator, MSB chunk first, with cascade pass-through.
// Optional signed compare of the top chunk is enabled by defining DATACMP_SIGNED_EN.
module datacmp_seq
    import datacmp_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CHUNK_W = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic [DATA_W-1:0] iData_a,
    input  logic [DATA_W-1:0] iData_b,
    input  logic [2:0]        iData,
`ifdef DATACMP_SIGNED_EN
    input  logic              iSigned,
`endif
    output logic              oReady,
    output logic              oValid,
    output logic [2:0]        oData
);

    localparam int unsigned NUM_CHUNKS = num_chunks(DATA_W, CHUNK_W);
    localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_CHUNKS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [2:0]        casc_q, casc_d;
    logic              valid_q, valid_d;
    logic [2:0]        data_q, data_d;
    logic              signed_q, signed_d;

    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic               chunk_signed;
    logic               chunk_gt;
    logic               chunk_lt;
    logic               start_signed;

`ifdef DATACMP_SIGNED_EN
    assign start_signed = iSigned;
`else
    assign start_signed = 1'b0;
`endif

    assign a_chunk = a_q[int'(idx_q) * CHUNK_W +: CHUNK_W];
    assign b_chunk = b_q[int'(idx_q) * CHUNK_W +: CHUNK_W];

    // Only the most significant chunk carries the sign.
    assign chunk_signed = signed_q && (idx_q == IDX_TOP);

    datacmp_chunk #(
        .CHUNK_W (CHUNK_W)
    ) u_chunk (
        .a_i      (a_chunk),
        .b_i      (b_chunk),
        .signed_i (chunk_signed),
        .gt_o     (chunk_gt),
        .lt_o     (chunk_lt)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        casc_d   = casc_q;
        signed_d = signed_q;
        valid_d  = 1'b0;
        data_d   = data_q;

        unique case (state_q)
            StIdle: begin
                if (iStart) begin
                    a_d      = iData_a;
                    b_d      = iData_b;
                    casc_d   = iData;
                    signed_d = start_signed;
                    idx_d    = IDX_TOP;
                    state_d  = StCmp;
                end
            end
            StCmp: begin
                if (chunk_gt) begin
                    data_d  = CMP_GT;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end else if (chunk_lt) begin
                    data_d  = CMP_LT;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end else if (idx_q == '0) begin
                    data_d  = casc_q;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= StIdle;
            idx_q    <= IDX_TOP;
            a_q      <= '0;
            b_q      <= '0;
            casc_q   <= '0;
            signed_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            casc_q   <= casc_d;
            signed_q <= signed_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    // A result pulse always lands in IDLE, so a start in the same cycle is accepted.
    assign oReady = (state_q == StIdle);
    assign oValid = valid_q;
    assign oData  = data_q;

endmodule

// File: tb/tb_datacmp_seq.sv
// Randomised self-checking bench for datacmp_seq against a behavioural compare model.
module tb_datacmp_seq;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int NC = DW / CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] da, db;
    logic [2:0]    casc;
    logic          sgn;
    logic          ready, valid;
    logic [2:0]    res;

    // Degenerate single-chunk instance
    logic          s1_start;
    logic [CW-1:0] s1_a, s1_b;
    logic [2:0]    s1_casc;
    logic          s1_ready, s1_valid;
    logic [2:0]    s1_res;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    datacmp_seq #(.DATA_W(DW), .CHUNK_W(CW)) dut (
        .iClk    (clk),
        .iRst    (rst),
        .iStart  (start),
        .iData_a (da),
        .iData_b (db),
        .iData   (casc),
`ifdef DATACMP_SIGNED_EN
        .iSigned (sgn),
`endif
        .oReady  (ready),
        .oValid  (valid),
        .oData   (res)
    );

    datacmp_seq #(.DATA_W(CW), .CHUNK_W(CW)) dut1 (
        .iClk    (clk),
        .iRst    (rst),
        .iStart  (s1_start),
        .iData_a (s1_a),
        .iData_b (s1_b),
        .iData   (s1_casc),
`ifdef DATACMP_SIGNED_EN
        .iSigned (1'b0),
`endif
        .oReady  (s1_ready),
        .oValid  (s1_valid),
        .oData   (s1_res)
    );

    // Model: chunks examined = position of the highest differing chunk counted from the top.
    function automatic int exp_lat(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] d;
        d = a ^ b;
        if (d == '0) return NC;
        for (int i = DW - 1; i >= 0; i--) begin
            if (d[i]) return NC - (i / CW);
        end
        return NC;
    endfunction

    function automatic logic [2:0] exp_res(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [2:0] c, input logic s);
        if (s) begin
            if ($signed(a) > $signed(b)) return 3'b100;
            if ($signed(a) < $signed(b)) return 3'b010;
        end else begin
            if (a > b) return 3'b100;
            if (a < b) return 3'b010;
        end
        return c;
    endfunction

    // Starts one compare from a negedge with ready high; returns edges-to-valid (-1 on timeout).
    // Leaves the bench at the negedge where valid is observed high.
    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] c,
                         input logic s, input bit noise, output int lat, output logic [2:0] r);
        da = a; db = b; casc = c; sgn = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        r = res;
        for (int n = 1; n <= NC + 3; n++) begin
            if (noise) begin
                start = 1'b1; da = $urandom; db = $urandom; casc = 3'($urandom);
            end
            @(negedge clk);
            if (valid) begin
                start = 1'b0;
                lat = n;
                r = res;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0 || res !== 3'b000) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b data=%b, need 1 0 000", ready, valid, res);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        int lat;
        logic [2:0] r;
        logic [DW-1:0] av [3] = '{32'hF000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
        logic [DW-1:0] bv [3] = '{32'h1000_0000, 32'h1234_5679, 32'hDEAD_BEEF};
        logic [2:0]    cv [3] = '{3'b001, 3'b000, 3'b011};
        int            lv [3] = '{1, 8, 8};
        logic [2:0]    rv [3] = '{3'b100, 3'b010, 3'b011};
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], bv[i], cv[i], 1'b0, 1'b0, lat, r);
            checks++;
            if (lat !== lv[i] || r !== rv[i]) begin
                errors++;
                $display("FAIL directed%0d: latency=%0d data=%b, need %0d %b", i, lat, r, lv[i],
                         rv[i]);
            end
            @(negedge clk);
            checks++;
            if (valid !== 1'b0 || res !== rv[i]) begin
                errors++;
                $display("FAIL hold%0d: valid=%b data=%b, need 0 %b", i, valid, res, rv[i]);
            end
        end
    endtask

    task automatic test_busy_window;
        int lat;
        int extra;
        logic [2:0] r;
        do_op(32'h0000_0001, 32'h0000_0002, 3'b111, 1'b0, 1'b1, lat, r);
        checks++;
        if (lat !== NC || r !== 3'b010) begin
            errors++;
            $display("FAIL busy: latency=%0d data=%b, need %0d 010", lat, r, NC);
        end
        // New start right in the valid cycle must be accepted.
        do_op(32'hFFFF_FFFF, 32'h0, 3'b000, 1'b0, 1'b0, lat, r);
        checks++;
        if (lat !== 1 || r !== 3'b100) begin
            errors++;
            $display("FAIL back_to_back: latency=%0d data=%b, need 1 100", lat, r);
        end
        extra = 0;
        repeat (NC + 2) begin
            @(negedge clk);
            if (valid) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL single_pulse: extra valids=%0d, need 0", extra);
        end
    endtask

    task automatic test_reset_mid;
        int extra;
        da = 32'h0000_FFFF; db = 32'h0000_FFFF; casc = 3'b101; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0 || res !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid: ready=%b valid=%b data=%b, need 1 0 000", ready, valid, res);
        end
        extra = 0;
        repeat (NC + 4) begin
            @(negedge clk);
            if (valid) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL reset_abort: valids after reset=%0d, need 0", extra);
        end
    endtask

    task automatic test_random;
        int lat;
        int el;
        logic [2:0] r;
        logic [2:0] er;
        logic [DW-1:0] a, b;
        logic [2:0] c;
        logic s;
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            // Perturb only a few low chunks so long equal runs are common.
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = a;
                default: b = a ^ (DW'($urandom) >> (CW * $urandom_range(1, NC - 1)));
            endcase
            c = 3'($urandom);
`ifdef DATACMP_SIGNED_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            el = exp_lat(a, b);
            er = exp_res(a, b, c, s);
            do_op(a, b, c, s, 1'($urandom), lat, r);
            checks++;
            if (lat !== el || r !== er) begin
                errors++;
                $display("FAIL random%0d a=%h b=%h c=%b s=%b: latency=%0d data=%b, need %0d %b",
                         i, a, b, c, s, lat, r, el, er);
            end
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
    endtask

    task automatic test_signed;
`ifdef DATACMP_SIGNED_EN
        int lat;
        logic [2:0] r;
        @(negedge clk);
        do_op(32'h8000_0000, 32'h0000_0001, 3'b000, 1'b1, 1'b0, lat, r);
        checks++;
        if (lat !== 1 || r !== 3'b010) begin
            errors++;
            $display("FAIL signed: latency=%0d data=%b, need 1 010", lat, r);
        end
        @(negedge clk);
        do_op(32'h8000_0000, 32'h0000_0001, 3'b000, 1'b0, 1'b0, lat, r);
        checks++;
        if (lat !== 1 || r !== 3'b100) begin
            errors++;
            $display("FAIL signed_off: latency=%0d data=%b, need 1 100", lat, r);
        end
`endif
    endtask

    task automatic test_single_chunk;
        int lat;
        logic [2:0] er;
        for (int i = 0; i < 12; i++) begin
            s1_a = 4'($urandom);
            s1_b = (i % 3 == 0) ? s1_a : 4'($urandom);
            s1_casc = 3'($urandom);
            er = (s1_a > s1_b) ? 3'b100 : (s1_a < s1_b) ? 3'b010 : s1_casc;
            s1_start = 1'b1;
            @(negedge clk);
            s1_start = 1'b0;
            lat = -1;
            for (int n = 1; n <= 4; n++) begin
                @(negedge clk);
                if (s1_valid) begin
                    lat = n;
                    break;
                end
            end
            checks++;
            if (lat !== 1 || s1_res !== er) begin
                errors++;
                $display("FAIL single_chunk%0d: latency=%0d data=%b, need 1 %b", i, lat, s1_res,
                         er);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; da = '0; db = '0; casc = '0; sgn = 1'b0;
        s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_casc = '0;
        @(negedge clk);
        test_reset;
        test_directed;
        @(negedge clk);
        test_busy_window;
        test_reset_mid;
        test_random;
        test_signed;
        @(negedge clk);
        test_single_chunk;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
